// File: rtl/act_sram_pkg.sv
// act_sram_pkg: shared constants, FSM state type and lane-slice helpers for the activation SRAM writer
package act_sram_pkg;
    localparam int PSUM_BW    = 24;
    localparam int ACT_BW     = 12;
    localparam int LANES      = 4;
    localparam int ADDR_BW    = 18;
    localparam int ROW_STRIDE = 57;
    localparam int PLANE_SIZE = 3249;
    localparam int SRAM_DEPTH = 207936;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [PSUM_BW-1:0] psum_lane(input logic [LANES*PSUM_BW-1:0] v, input int k);
        return v[k*PSUM_BW +: PSUM_BW];
    endfunction

    function automatic logic [ACT_BW-1:0] act_lane(input logic [LANES*ACT_BW-1:0] v, input int k);
        return v[k*ACT_BW +: ACT_BW];
    endfunction
endpackage

// File: rtl/act_requant_lane.sv
// act_requant_lane: rounding arithmetic right shift, optional ReLU and 12-bit saturation for one lane
module act_requant_lane
    import act_sram_pkg::*;
(
    input  logic [PSUM_BW-1:0] psum,
    input  logic [4:0]         shift,
    input  logic               relu,
    output logic [ACT_BW-1:0]  act
);
    localparam logic signed [PSUM_BW:0] MAXV = (PSUM_BW+1)'((1 << (ACT_BW-1)) - 1);
    localparam logic signed [PSUM_BW:0] MINV = -MAXV - (PSUM_BW+1)'(1);
    logic signed [PSUM_BW:0] ext, rnd, sum, shr;
    always_comb begin
        ext = {psum[PSUM_BW-1], psum};
        rnd = (shift == 5'd0) ? '0 : (PSUM_BW+1)'(1) << (shift - 5'd1);
        sum = ext + rnd;
        shr = sum >>> shift;
        act = (relu && shr[PSUM_BW]) ? '0 :
              (shr > MAXV) ? MAXV[ACT_BW-1:0] :
              (shr < MINV) ? MINV[ACT_BW-1:0] : shr[ACT_BW-1:0];
    end
endmodule

// File: rtl/act_sram_writer.sv
// act_sram_writer: requantizes 4-lane psum groups and writes them in raster order to the activation SRAM
module act_sram_writer
    import act_sram_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [5:0]                 cfg_width,
    input  logic [5:0]                 cfg_height,
    input  logic [6:0]                 cfg_groups,
    input  logic [ADDR_BW-1:0]         cfg_base,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_relu,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*PSUM_BW-1:0]   in_psum,
    input  logic [LANES-1:0]           in_lane_en,
    output logic                       sram_csb,
    output logic                       sram_wsb,
    output logic                       sram_msb,
    output logic [LANES-1:0]           sram_wordmask,
    output logic [ADDR_BW-1:0]         sram_waddr,
    output logic [LANES*ACT_BW-1:0]    sram_wdata,
    output logic                       busy,
    output logic                       done
);
    state_t state, nxt;
    logic [5:0] w_q, h_q, x, y;
    logic [6:0] g_q, g;
    logic [4:0] shift_q;
    logic relu_q, drain_cnt, accept, last, cfg_zero, s1_valid, s1_wr;
    logic [ADDR_BW-1:0] plane_base, row_base, s1_addr;
    logic [LANES-1:0] s1_en;
    logic [LANES*ACT_BW-1:0] act_w, s1_data;

    assign accept   = in_valid && in_ready;
    assign cfg_zero = (cfg_width == 6'd0) || (cfg_height == 6'd0) || (cfg_groups == 7'd0);
    assign last     = accept && (x == w_q - 6'd1) && (y == h_q - 6'd1) && (g == g_q - 7'd1);
    assign s1_wr    = s1_valid && (s1_en != '0);
    assign sram_msb = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = (state == IDLE)  ? (start ? (cfg_zero ? DONE : RUN) : IDLE) :
              (state == RUN)   ? (last ? DRAIN : RUN) :
              (state == DRAIN) ? (drain_cnt ? DONE : DRAIN) : IDLE;
    end

    always_comb begin
        in_ready = (state == RUN);
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

    // raster counters; row_base always equals base + g*PLANE_SIZE + y*ROW_STRIDE
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q        <= '0;
            h_q        <= '0;
            g_q        <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            x          <= '0;
            y          <= '0;
            g          <= '0;
            plane_base <= '0;
            row_base   <= '0;
            drain_cnt  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                w_q        <= cfg_width;
                h_q        <= cfg_height;
                g_q        <= cfg_groups;
                shift_q    <= cfg_shift;
                relu_q     <= cfg_relu;
                x          <= '0;
                y          <= '0;
                g          <= '0;
                plane_base <= cfg_base;
                row_base   <= cfg_base;
            end
            if (accept) begin
                if (x == w_q - 6'd1) begin
                    x <= '0;
                    if (y == h_q - 6'd1) begin
                        y          <= '0;
                        g          <= g + 7'd1;
                        plane_base <= plane_base + ADDR_BW'(PLANE_SIZE);
                        row_base   <= plane_base + ADDR_BW'(PLANE_SIZE);
                    end else begin
                        y        <= y + 6'd1;
                        row_base <= row_base + ADDR_BW'(ROW_STRIDE);
                    end
                end else begin
                    x <= x + 6'd1;
                end
            end
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        act_requant_lane u_lane (
            .psum  (psum_lane(in_psum, i)),
            .shift (shift_q),
            .relu  (relu_q),
            .act   (act_w[i*ACT_BW +: ACT_BW])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_en   <= in_lane_en;
            s1_addr <= row_base + ADDR_BW'(x);
            s1_data <= act_w;
        end
    end

    // address and data hold their last written values across idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_csb      <= 1'b1;
            sram_wsb      <= 1'b1;
            sram_wordmask <= '1;
            sram_waddr    <= '0;
            sram_wdata    <= '0;
        end else begin
            sram_csb      <= ~s1_wr;
            sram_wsb      <= ~s1_wr;
            sram_wordmask <= s1_wr ? ~s1_en : '1;
            if (s1_wr) begin
                sram_waddr <= s1_addr;
                sram_wdata <= s1_data;
            end
        end
    end
endmodule

// File: tb/tb_act_sram_writer.sv
// tb_act_sram_writer: directed scoreboard bench for act_sram_writer
module tb_act_sram_writer;
    logic clk = 0, rst = 1, start = 0, cfg_relu = 0, in_valid = 0;
    logic [5:0] cfg_width = 0, cfg_height = 0;
    logic [6:0] cfg_groups = 0;
    logic [17:0] cfg_base = 0;
    logic [4:0] cfg_shift = 0;
    logic [95:0] in_psum = 0;
    logic [3:0] in_lane_en = 0;
    logic in_ready, sram_csb, sram_wsb, sram_msb, busy, done;
    logic [3:0] sram_wordmask;
    logic [17:0] sram_waddr;
    logic [47:0] sram_wdata;

    act_sram_writer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_groups(cfg_groups), .cfg_base(cfg_base), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum), .in_lane_en(in_lane_en),
        .sram_csb(sram_csb), .sram_wsb(sram_wsb), .sram_msb(sram_msb), .sram_wordmask(sram_wordmask),
        .sram_waddr(sram_waddr), .sram_wdata(sram_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [17:0] a; logic [47:0] d; logic [3:0] m;} wr_t;
    wr_t q[$];
    int vectors = 0, miscompares = 0, writes = 0;
    int bw, bh, bbase, bshift, px_x, px_y, px_g;
    bit brelu;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!rst && sram_csb === 1'b0) begin
            writes++;
            chk("write_expected", 64'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("waddr", sram_waddr, e.a);
                chk("wdata", sram_wdata, e.d);
                chk("wordmask", sram_wordmask, e.m);
                chk("wsb", sram_wsb, 0);
            end
        end
    end

    function automatic logic [11:0] rq(input int p, input int s, input bit relu);
        int r;
        r = (s == 0) ? p : (p + (1 << (s - 1))) >>> s;
        if (relu && r < 0) r = 0;
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
        return 12'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_csb"}, sram_csb, 1);
        chk({tag, "_wsb"}, sram_wsb, 1);
        chk({tag, "_msb"}, sram_msb, 1);
        chk({tag, "_mask"}, sram_wordmask, 4'hF);
        chk({tag, "_waddr"}, sram_waddr, 0);
        chk({tag, "_wdata"}, sram_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic layer(input int w, input int h, input int g, input int base, input int s, input bit relu);
        cfg_width = 6'(w); cfg_height = 6'(h); cfg_groups = 7'(g);
        cfg_base = 18'(base); cfg_shift = 5'(s); cfg_relu = relu;
        bw = w; bh = h; bbase = base; bshift = s; brelu = relu;
        px_x = 0; px_y = 0; px_g = 0;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic pxe(input logic [95:0] p, input logic [3:0] en, input logic [47:0] d);
        int addr;
        addr = bbase + px_g * 3249 + px_y * 57 + px_x;
        if (en != 0) q.push_back({18'(addr), d, ~en});
        if (++px_x == bw) begin
            px_x = 0;
            if (++px_y == bh) begin px_y = 0; px_g++; end
        end
        in_psum = p; in_lane_en = en; in_valid = 1;
        tick();
    endtask

    task automatic px(input logic [95:0] p, input logic [3:0] en);
        logic [47:0] d;
        for (int k = 0; k < 4; k++) d[12*k +: 12] = rq(int'($signed(p[24*k +: 24])), bshift, brelu);
        pxe(p, en, d);
    endtask

    task automatic finish_layer(input int exp_lat);
        int n;
        n = 0;
        in_valid = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk);
            if (done) n = i;
        end
        chk("done_latency", n, exp_lat);
        chk("busy_at_done", busy, 1);
        chk("pending_writes", q.size(), 0);
        tick();
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        logic [95:0] p;
        int w0;
        repeat (2) tick();
        chk_reset("reset");
        rst = 0;
        tick();

        layer(2, 2, 1, 0, 0, 0);
        chk("busy_after_start", busy, 1);
        chk("ready_in_run", in_ready, 1);
        p = {24'd4, 24'd3, 24'd2, 24'd1};
        repeat (4) pxe(p, 4'hF, 48'h004_003_002_001);
        finish_layer(3);

        layer(1, 1, 1, 0, 4, 0);
        pxe({-24'sd40000, 24'sd40000, -24'sd24, 24'sd24}, 4'hF, 48'h800_7FF_FFF_002);
        finish_layer(3);
        layer(1, 1, 1, 0, 4, 1);
        pxe({-24'sd40000, 24'sd40000, -24'sd24, 24'sd24}, 4'hF, 48'h000_7FF_000_002);
        finish_layer(3);

        layer(1, 1, 3, 100, 5, 1);
        px({$urandom(), $urandom(), $urandom()}, 4'hF);
        in_valid = 0;
        cfg_base = 18'd7; cfg_groups = 7'd0; start = 1;
        tick();
        start = 0;
        chk("start_ignored_busy", busy, 1);
        px({$urandom(), $urandom(), $urandom()}, 4'hF);
        in_valid = 0;
        tick();
        px({$urandom(), $urandom(), $urandom()}, 4'hF);
        finish_layer(3);

        layer(3, 1, 1, 10, 3, 0);
        w0 = writes;
        px({$urandom(), $urandom(), $urandom()}, 4'b0101);
        px({$urandom(), $urandom(), $urandom()}, 4'b0000);
        px({$urandom(), $urandom(), $urandom()}, 4'hF);
        finish_layer(3);
        chk("lane_en0_write_count", writes - w0, 2);

        layer(4, 1, 1, 500, 0, 0);
        px({24'd9, 24'd8, 24'd7, 24'd6}, 4'hF);
        in_valid = 0;
        repeat (3) tick();
        in_psum = {24'd1, 24'd1, 24'd1, 24'd1}; in_lane_en = 4'hF; in_valid = 1;
        tick();
        in_valid = 0; rst = 1;
        tick();
        chk_reset("midrun_reset");
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", done, 0);
        end
        tick();
        chk("queue_after_reset", q.size(), 0);
        layer(1, 1, 1, 500, 0, 0);
        px({24'd5, 24'd5, 24'd5, 24'd5}, 4'hF);
        finish_layer(3);

        w0 = writes;
        layer(3, 3, 0, 0, 0, 0);
        finish_layer(1);
        chk("g0_no_writes", writes - w0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
